// File: rtl/change_dispenser_pkg.sv
// Currency codes, note values and dispenser state encoding shared with the payment FSM.
package change_dispenser_pkg;

  localparam logic [3:0] CUR_NONE = 4'b0000;
  localparam logic [3:0] CUR_5    = 4'b0001;
  localparam logic [3:0] CUR_10   = 4'b0010;
  localparam logic [3:0] CUR_20   = 4'b0011;
  localparam logic [3:0] CUR_50   = 4'b0100;
  localparam logic [3:0] CUR_100  = 4'b0101;
  localparam logic [3:0] CUR_500  = 4'b0110;
  localparam logic [3:0] CUR_1000 = 4'b0111;
  localparam logic [3:0] CUR_END  = 4'b1000;

  localparam int NUM_DENOM = 7;
  localparam int AMT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_FINISH
  } disp_state_t;

  function automatic logic [AMT_W-1:0] cur_value(input logic [3:0] code);
    logic [AMT_W-1:0] val;
    case (code)
      CUR_5:    val = 16'd5;
      CUR_10:   val = 16'd10;
      CUR_20:   val = 16'd20;
      CUR_50:   val = 16'd50;
      CUR_100:  val = 16'd100;
      CUR_500:  val = 16'd500;
      CUR_1000: val = 16'd1000;
      default:  val = 16'd0;
    endcase
    return val;
  endfunction

  function automatic logic cur_legal(input logic [3:0] code);
    return (code != CUR_NONE) && (code < CUR_END);
  endfunction

endpackage

// File: rtl/change_dispenser_note_stock_bank.sv
// Per-denomination note stock: saturating refill, single decrement port, nonzero flags.
// Bit gi of nonzero corresponds to currency code gi+1.
module note_stock_bank
  import change_dispenser_pkg::*;
#(
  parameter int              CNT_W      = 8,
  parameter logic [CNT_W-1:0] INIT_STOCK = CNT_W'(20)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 refill_en,
  input  logic [3:0]           refill_code,
  input  logic [CNT_W-1:0]     refill_count,
  input  logic                 dec_en,
  input  logic [3:0]           dec_code,
  output logic [NUM_DENOM-1:0] nonzero
);

  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_cnt
      localparam logic [3:0] CODE = 4'(gi + 1);

      logic [CNT_W-1:0] stock_reg;
      logic [CNT_W-1:0] stock_next;
      logic [CNT_W:0]   sum;

      always_comb begin
        sum        = {1'b0, stock_reg} + {1'b0, refill_count};
        stock_next = stock_reg;
        if (refill_en && (refill_code == CODE)) begin
          // Carry out of the add means the counter would wrap: clamp to full scale.
          stock_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (dec_en && (dec_code == CODE) && (stock_reg != '0)) begin
          stock_next = stock_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          stock_reg <= INIT_STOCK;
        end else begin
          stock_reg <= stock_next;
        end
      end

      assign nonzero[gi] = (stock_reg != '0);
    end
  endgenerate

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one note at a time, largest affordable in-stock denomination
// first, and reports whatever could not be dispensed.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int              CNT_W      = 8,
  parameter logic [CNT_W-1:0] INIT_STOCK = CNT_W'(20)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      amount,
  input  logic             disp_ready,
  input  logic             refill_valid,
  input  logic [3:0]       refill_code,
  input  logic [CNT_W-1:0] refill_count,
  output logic             note_valid,
  output logic [3:0]       note_code,
  output logic             busy,
  output logic             done,
  output logic [15:0]      remainder,
  output logic [CNT_W-1:0] note_count
);

  disp_state_t state_reg, state_next;
  logic [AMT_W-1:0] rem_reg, rem_next;
  logic [AMT_W-1:0] remainder_reg, remainder_next;
  logic [3:0]       code_reg, code_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic                 refill_en;
  logic                 dec_en;
  logic [NUM_DENOM-1:0] nonzero;
  logic [NUM_DENOM-1:0] eligible;
  logic [3:0]           pick_code;
  logic                 pick_found;

  note_stock_bank #(
    .CNT_W      (CNT_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk          (clk),
    .rst          (rst),
    .refill_en    (refill_en),
    .refill_code  (refill_code),
    .refill_count (refill_count),
    .dec_en       (dec_en),
    .dec_code     (code_reg),
    .nonzero      (nonzero)
  );

  generate
    for (genvar gi = 0; gi < NUM_DENOM; gi++) begin : g_elig
      assign eligible[gi] = nonzero[gi] && (cur_value(4'(gi + 1)) <= rem_reg);
    end
  endgenerate

  // Ascending scan so the highest eligible code is the one left standing.
  always_comb begin
    pick_code  = CUR_NONE;
    pick_found = |eligible;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (eligible[i]) begin
        pick_code = 4'(i + 1);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    remainder_next = remainder_reg;
    code_next      = code_reg;
    count_next     = count_reg;
    refill_en      = 1'b0;
    dec_en         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        refill_en = refill_valid && cur_legal(refill_code);
        if (start) begin
          rem_next   = amount;
          count_next = '0;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick_found) begin
          code_next  = pick_code;
          state_next = ST_ISSUE;
        end else begin
          remainder_next = rem_reg;
          state_next     = ST_FINISH;
        end
      end
      ST_ISSUE: begin
        if (disp_ready) begin
          rem_next   = rem_reg - cur_value(code_reg);
          dec_en     = 1'b1;
          count_next = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
          state_next = ST_SELECT;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rem_reg       <= '0;
      remainder_reg <= '0;
      code_reg      <= CUR_NONE;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      rem_reg       <= rem_next;
      remainder_reg <= remainder_next;
      code_reg      <= code_next;
      count_reg     <= count_next;
    end
  end

  assign note_valid = (state_reg == ST_ISSUE);
  assign note_code  = code_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_FINISH);
  assign remainder  = remainder_reg;
  assign note_count = count_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (stock 20 and stock 1) checked against a
// greedy note-queue model every cycle, plus literal expectations for each scenario.
module tb_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst          [2];
  logic        start        [2];
  logic [15:0] amount       [2];
  logic        disp_ready   [2];
  logic        refill_valid [2];
  logic [3:0]  refill_code  [2];
  logic [7:0]  refill_count [2];
  logic        note_valid   [2];
  logic [3:0]  note_code    [2];
  logic        busy         [2];
  logic        done         [2];
  logic [15:0] remainder    [2];
  logic [7:0]  note_count   [2];

  change_dispenser #(.CNT_W(8), .INIT_STOCK(8'd20)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .amount(amount[0]),
    .disp_ready(disp_ready[0]), .refill_valid(refill_valid[0]),
    .refill_code(refill_code[0]), .refill_count(refill_count[0]),
    .note_valid(note_valid[0]), .note_code(note_code[0]), .busy(busy[0]),
    .done(done[0]), .remainder(remainder[0]), .note_count(note_count[0])
  );

  change_dispenser #(.CNT_W(8), .INIT_STOCK(8'd1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .amount(amount[1]),
    .disp_ready(disp_ready[1]), .refill_valid(refill_valid[1]),
    .refill_code(refill_code[1]), .refill_count(refill_count[1]),
    .note_valid(note_valid[1]), .note_code(note_code[1]), .busy(busy[1]),
    .done(done[1]), .remainder(remainder[1]), .note_count(note_count[1])
  );

  // Model state
  int checks = 0;
  int failures = 0;
  int init_stock [2] = '{20, 1};
  int stock [2][8];
  int exp_q [2][$];
  int log_q [2][$];
  int exp_rem [2];
  int exp_cnt [2];
  bit pending [2];
  int seq7 [7] = '{7, 6, 5, 4, 3, 2, 1};

  function automatic int value_of(int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 20;
      4: return 50;
      5: return 100;
      6: return 500;
      7: return 1000;
      default: return 0;
    endcase
  endfunction

  task automatic chk(int i, string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL dut%0d %s actual=%0d expected=%0d", i, name, act, exp);
    end
  endtask

  task automatic model_reset(int i);
    for (int d = 1; d <= 7; d++) stock[i][d] = init_stock[i];
    exp_q[i].delete();
    pending[i] = 0;
  endtask

  task automatic model_start(int i, int amt);
    int rem;
    rem = amt;
    exp_q[i].delete();
    log_q[i].delete();
    for (int d = 7; d >= 1; d--) begin
      while (value_of(d) <= rem && stock[i][d] > 0) begin
        exp_q[i].push_back(d);
        rem -= value_of(d);
        stock[i][d]--;
      end
    end
    exp_rem[i] = rem;
    exp_cnt[i] = (exp_q[i].size() > 255) ? 255 : exp_q[i].size();
    pending[i] = 1;
  endtask

  task automatic model_refill(int i, int code, int cnt);
    if (!pending[i] && code >= 1 && code <= 7) begin
      stock[i][code] = (stock[i][code] + cnt > 255) ? 255 : stock[i][code] + cnt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of request/refill; model sees refill before start, as the DUT does.
  task automatic drive(int i, bit st, int amt, bit rv, int rc, int rn, output int t0);
    start[i]        = st;
    amount[i]       = 16'(amt);
    refill_valid[i] = rv;
    refill_code[i]  = 4'(rc);
    refill_count[i] = 8'(rn);
    t0 = cyc;
    tick();
    if (rv) model_refill(i, rc, rn);
    if (st && !pending[i]) model_start(i, amt);
    start[i]        = 1'b0;
    refill_valid[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget, output int dcyc);
    bit seen;
    seen = 0;
    dcyc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done[i]) begin
        seen = 1;
        dcyc = cyc;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL dut%0d done_timeout actual=no_done required=done_within_%0d", i, budget);
    end
    tick();
  endtask

  task automatic wait_valid(int i, int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (note_valid[i]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL dut%0d valid_timeout actual=no_note required=note_within_%0d", i, budget);
    end
    tick();
  endtask

  task automatic check_log7(int i);
    chk(i, "seq_len", log_q[i].size(), 7);
    for (int k = 0; k < 7 && k < log_q[i].size(); k++) chk(i, "seq_code", log_q[i][k], seq7[k]);
  endtask

  task automatic check_reset_outputs(int i);
    chk(i, "rst_note_valid", note_valid[i], 0);
    chk(i, "rst_note_code", note_code[i], 0);
    chk(i, "rst_busy", busy[i], 0);
    chk(i, "rst_done", done[i], 0);
    chk(i, "rst_remainder", remainder[i], 0);
    chk(i, "rst_note_count", note_count[i], 0);
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst[i]) begin
          chk(i, "busy", busy[i], pending[i]);
          if (note_valid[i]) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL dut%0d note_extra actual=%0d required=no_note", i, note_code[i]);
            end else begin
              chk(i, "note_code", note_code[i], exp_q[i][0]);
              if (disp_ready[i]) begin
                log_q[i].push_back(int'(note_code[i]));
                void'(exp_q[i].pop_front());
              end
            end
          end
          if (done[i]) begin
            if (!pending[i]) begin
              checks++;
              failures++;
              $display("FAIL dut%0d done_extra actual=1 required=0", i);
            end else begin
              chk(i, "notes_left", exp_q[i].size(), 0);
              chk(i, "remainder", remainder[i], exp_rem[i]);
              chk(i, "note_count", note_count[i], exp_cnt[i]);
            end
            pending[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int dc;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; amount[i] = '0; disp_ready[i] = 1'b1;
      refill_valid[i] = 1'b0; refill_code[i] = '0; refill_count[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check_reset_outputs(i);
      model_reset(i);
      rst[i] = 1'b0;
    end
    tick();

    // 1685 with ready high: seven notes, one of each, done 16 cycles after start
    drive(0, 1, 1685, 0, 0, 0, t0);
    wait_done(0, 100, dc);
    chk(0, "lat_1685", dc - t0, 16);
    chk(0, "rem_1685", remainder[0], 0);
    chk(0, "cnt_1685", note_count[0], 7);
    check_log7(0);

    // Second 1685 with a start pulse mid-request that must be ignored
    drive(0, 1, 1685, 0, 0, 0, t0);
    tick();
    tick();
    drive(0, 1, 40, 0, 0, 0, dc);
    wait_done(0, 100, dc);
    chk(0, "lat_busy_start", dc - t0, 16);
    chk(0, "rem_busy_start", remainder[0], 0);
    check_log7(0);

    // Below the smallest note
    drive(0, 1, 3, 0, 0, 0, t0);
    wait_done(0, 20, dc);
    chk(0, "lat_3", dc - t0, 2);
    chk(0, "rem_3", remainder[0], 3);
    chk(0, "cnt_3", note_count[0], 0);

    // 30 with the ejector stalled on the first note
    disp_ready[0] = 1'b0;
    drive(0, 1, 30, 0, 0, 0, t0);
    wait_valid(0, 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(0, "hold_valid", note_valid[0], 1);
      chk(0, "hold_code", note_code[0], 3);
    end
    tick();
    disp_ready[0] = 1'b1;
    wait_done(0, 50, dc);
    chk(0, "rem_30", remainder[0], 0);
    chk(0, "cnt_30", note_count[0], 2);
    chk(0, "seq30_len", log_q[0].size(), 2);
    if (log_q[0].size() == 2) begin
      chk(0, "seq30_first", log_q[0][0], 3);
      chk(0, "seq30_second", log_q[0][1], 2);
    end

    // One note of each: 2000 leaves 315 and empties every counter
    drive(1, 1, 2000, 0, 0, 0, t0);
    wait_done(1, 100, dc);
    chk(1, "lat_2000", dc - t0, 16);
    chk(1, "rem_2000", remainder[1], 315);
    chk(1, "cnt_2000", note_count[1], 7);
    check_log7(1);
    drive(1, 1, 10, 0, 0, 0, t0);
    wait_done(1, 20, dc);
    chk(1, "rem_empty", remainder[1], 10);
    chk(1, "cnt_empty", note_count[1], 0);
    chk(1, "lat_empty", dc - t0, 2);

    // Saturating refills of 5s and 10s, illegal codes ignored, then a note_count overflow
    drive(1, 0, 0, 1, 1, 250, dc);
    drive(1, 0, 0, 1, 1, 250, dc);
    drive(1, 0, 0, 1, 2, 200, dc);
    drive(1, 0, 0, 1, 2, 200, dc);
    drive(1, 0, 0, 1, 0, 100, dc);
    drive(1, 0, 0, 1, 8, 100, dc);
    drive(1, 1, 65535, 0, 0, 0, t0);
    wait_done(1, 1200, dc);
    chk(1, "lat_sat", dc - t0, 1022);
    chk(1, "rem_sat", remainder[1], 61710);
    chk(1, "cnt_sat", note_count[1], 255);

    // Refill together with start counts; refill while busy does not
    disp_ready[1] = 1'b0;
    drive(1, 1, 25, 1, 3, 1, t0);
    wait_valid(1, 10);
    drive(1, 0, 0, 1, 1, 3, dc);
    tick();
    disp_ready[1] = 1'b1;
    wait_done(1, 20, dc);
    chk(1, "rem_refill_busy", remainder[1], 5);
    chk(1, "cnt_refill_busy", note_count[1], 1);

    // Reset while a note is presented
    drive(1, 0, 0, 1, 7, 1, dc);
    disp_ready[1] = 1'b0;
    drive(1, 1, 1000, 0, 0, 0, t0);
    wait_valid(1, 10);
    rst[1] = 1'b1;
    tick();
    model_reset(1);
    check_reset_outputs(1);
    rst[1] = 1'b0;
    disp_ready[1] = 1'b1;
    tick();
    drive(1, 1, 2000, 0, 0, 0, t0);
    wait_done(1, 100, dc);
    chk(1, "rem_after_rst", remainder[1], 315);
    chk(1, "cnt_after_rst", note_count[1], 7);
    chk(1, "lat_after_rst", dc - t0, 16);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
